// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data ports
// Data has fixed priority; a saturating counter hands a contended grant to fetch after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int NBITS        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iproc_req,
  input  logic [NBITS-1:0] iaddr,
  output logic             imem_rdy,
  output logic             ivalid,
  output logic [NBITS-1:0] idata,
  input  logic             dproc_req,
  input  logic [NBITS-1:0] daddr,
  input  logic [NBITS-1:0] wdata2mem,
  input  logic             wenMem,
  output logic             dmem_rdy,
  output logic             dvalid,
  output logic [NBITS-1:0] ddata,
  output logic             mem_req,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic             mem_wen,
  input  logic             mem_rdy,
  input  logic             mem_valid,
  input  logic [NBITS-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dwen_q, dwen_d;
  logic             ivalid_q, ivalid_d;
  logic             dvalid_q, dvalid_d;
  logic [NBITS-1:0] idata_q, idata_d;
  logic [NBITS-1:0] ddata_q, ddata_d;
  logic             gnt_i, gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dwen_q   <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      idata_q  <= '0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwen_q   <= dwen_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      idata_q  <= idata_d;
      ddata_q  <= ddata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dwen_d    = dwen_q;
    ivalid_d  = 1'b0;
    dvalid_d  = 1'b0;
    idata_d   = idata_q;
    ddata_d   = ddata_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    imem_rdy  = 1'b0;
    dmem_rdy  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = dproc_req & (~iproc_req | (cnt_q != LIMIT));
        gnt_i = iproc_req & ~gnt_d;
        if (gnt_d | gnt_i) begin
          mem_req   = 1'b1;
          mem_addr  = gnt_d ? daddr : iaddr;
          mem_wdata = wdata2mem;
          mem_wen   = gnt_d & wenMem;
        end
        imem_rdy = gnt_i & mem_rdy;
        dmem_rdy = gnt_d & mem_rdy;
        if (dmem_rdy) begin
          state_d = DBUSY;
          // Remember load/store: the core may change wenMem once it sees dmem_rdy.
          dwen_d  = wenMem;
          if (iproc_req) cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + 4'd1;
          else           cnt_d = '0;
        end else if (imem_rdy) begin
          state_d = IBUSY;
          cnt_d   = '0;
        end
      end
      IBUSY: begin
        if (mem_valid) begin
          state_d  = IDLE;
          ivalid_d = 1'b1;
          idata_d  = mem_rdata;
        end
      end
      DBUSY: begin
        if (mem_valid) begin
          state_d  = IDLE;
          dvalid_d = 1'b1;
          if (!dwen_q) ddata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ivalid = ivalid_q;
  assign dvalid = dvalid_q;
  assign idata  = idata_q;
  assign ddata  = ddata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iproc_req, dproc_req, wenMem, mem_rdy, mem_valid;
  logic [31:0] iaddr, daddr, wdata2mem, mem_rdata;
  logic        imem_rdy, ivalid, dmem_rdy, dvalid, mem_req, mem_wen;
  logic [31:0] idata, ddata, mem_addr, mem_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_ddata;
  logic        exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mem_port_arbiter #(.NBITS(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .iproc_req(iproc_req), .iaddr(iaddr), .imem_rdy(imem_rdy), .ivalid(ivalid), .idata(idata),
    .dproc_req(dproc_req), .daddr(daddr), .wdata2mem(wdata2mem), .wenMem(wenMem),
    .dmem_rdy(dmem_rdy), .dvalid(dvalid), .ddata(ddata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdy(mem_rdy), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; iproc_req = 0; dproc_req = 0; wenMem = 0; mem_rdy = 0; mem_valid = 0;
    iaddr = '0; daddr = '0; wdata2mem = '0; mem_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_ivalid", ivalid, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_idata", idata, 0);
    chk("rst_ddata", ddata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cnt", dut.cnt_q, 0);

    // Lone fetch
    iproc_req = 1; iaddr = 32'h100; mem_rdy = 1;
    #1;
    chk("lf_imem_rdy", imem_rdy, 1);
    chk("lf_dmem_rdy", dmem_rdy, 0);
    chk("lf_mem_addr", mem_addr, 32'h100);
    chk("lf_mem_wen", mem_wen, 0);
    cyc();
    iproc_req = 0; mem_rdy = 0;
    chk("lf_busy_req", mem_req, 0);
    cyc();
    mem_valid = 1; mem_rdata = 32'h0050_0093;
    chk("lf_ivalid_early", ivalid, 0);
    cyc();
    mem_valid = 0;
    chk("lf_ivalid", ivalid, 1);
    chk("lf_idata", idata, 32'h0050_0093);
    cyc();
    chk("lf_ivalid_pulse", ivalid, 0);
    chk("lf_idata_hold", idata, 32'h0050_0093);

    // Contention: data first, then fetch
    iproc_req = 1; iaddr = 32'h104; dproc_req = 1; daddr = 32'h2000; wenMem = 0; mem_rdy = 1;
    #1;
    chk("ct_dmem_rdy", dmem_rdy, 1);
    chk("ct_imem_rdy", imem_rdy, 0);
    chk("ct_mem_addr_d", mem_addr, 32'h2000);
    cyc();
    dproc_req = 0;
    chk("ct_busy_imem_rdy", imem_rdy, 0);
    mem_valid = 1; mem_rdata = 32'h1111_2222;
    cyc();
    mem_valid = 0;
    chk("ct_dvalid", dvalid, 1);
    chk("ct_ddata", ddata, 32'h1111_2222);
    chk("ct_imem_rdy2", imem_rdy, 1);
    chk("ct_mem_addr_i", mem_addr, 32'h104);
    cyc();
    iproc_req = 0;
    mem_valid = 1; mem_rdata = 32'h0000_0013;
    cyc();
    mem_valid = 0;
    chk("ct_ivalid", ivalid, 1);
    chk("ct_idata", idata, 32'h0000_0013);
    chk("ct_cnt", dut.cnt_q, 0);

    // Starvation guard: D,D,D,D,I,D
    iproc_req = 1; dproc_req = 1; iaddr = 32'h200; daddr = 32'h3000; mem_rdy = 1;
    last_ddata = 32'h1111_2222;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("sv_dgnt%0d", k), dmem_rdy, exp_d[k]);
      chk($sformatf("sv_ignt%0d", k), imem_rdy, !exp_d[k]);
      cyc();
      mem_valid = 1; mem_rdata = 32'hA5A5_0000 + k;
      if (exp_d[k]) last_ddata = 32'hA5A5_0000 + k;
      cyc();
      mem_valid = 0;
      if (k == 4) chk("sv_cnt_clear", dut.cnt_q, 0);
      if (k == 3) chk("sv_cnt_sat", dut.cnt_q, 4);
    end
    chk("sv_ddata", ddata, last_ddata);
    iproc_req = 0; dproc_req = 0;
    cyc();

    // Store
    dproc_req = 1; wenMem = 1; daddr = 32'h40; wdata2mem = 32'hDEAD_BEEF; mem_rdy = 1;
    #1;
    chk("st_dmem_rdy", dmem_rdy, 1);
    chk("st_mem_wen", mem_wen, 1);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_addr", mem_addr, 32'h40);
    cyc();
    dproc_req = 0; wenMem = 0; wdata2mem = '0;
    mem_valid = 1; mem_rdata = 32'h1234_5678;
    cyc();
    mem_valid = 0;
    chk("st_dvalid", dvalid, 1);
    chk("st_ddata_hold", ddata, last_ddata);
    cyc();

    // Backpressure
    dproc_req = 1; daddr = 32'h80; mem_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_req%0d", k), mem_req, 1);
      chk($sformatf("bp_rdy%0d", k), dmem_rdy, 0);
      cyc();
    end
    mem_rdy = 1;
    #1;
    chk("bp_accept", dmem_rdy, 1);
    cyc();
    dproc_req = 0;
    chk("bp_busy_req", mem_req, 0);
    mem_valid = 1; mem_rdata = 32'h0BAD_F00D;
    cyc();
    mem_valid = 0;
    chk("bp_dvalid", dvalid, 1);
    chk("bp_ddata", ddata, 32'h0BAD_F00D);
    cyc();

    // Reset while in DBUSY, late mem_valid ignored
    dproc_req = 1; daddr = 32'h90; mem_rdy = 1;
    cyc();
    dproc_req = 0;
    rst = 1;
    cyc();
    rst = 0;
    mem_valid = 1; mem_rdata = 32'hFFFF_0000;
    #1;
    chk("rs_idle_req", mem_req, 0);
    cyc();
    mem_valid = 0;
    chk("rs_dvalid", dvalid, 0);
    chk("rs_ddata", ddata, 0);
    chk("rs_ivalid", ivalid, 0);
    dproc_req = 1; daddr = 32'hA0;
    #1;
    chk("rs_regrant", dmem_rdy, 1);
    chk("rs_mem_addr", mem_addr, 32'hA0);
    cyc();
    dproc_req = 0;
    mem_valid = 1; mem_rdata = 32'h0000_00A0;
    cyc();
    mem_valid = 0;
    chk("rs_dvalid2", dvalid, 1);
    chk("rs_ddata2", ddata, 32'h0000_00A0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
